// File: rtl/arrhythmia_pkg.sv
// -----------------------------------------------------------------------------
// arrhythmia_pkg
// Shared definitions for the arrhythmia scoring block: scoring FSM state
// encoding and the default score width / run length.
// No ports (package).
// -----------------------------------------------------------------------------
package arrhythmia_pkg;

    localparam int DEFAULT_BITSIZE  = 20;
    localparam int DEFAULT_MAX_DATA = 101;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        WAIT_LABEL = 2'd2,
        DONE       = 2'd3
    } state_t;

endpackage : arrhythmia_pkg

// File: rtl/sm_compare.sv
// -----------------------------------------------------------------------------
// sm_compare
// Combinational "a > b" for sign-magnitude operands (MSB = sign, remaining
// bits = magnitude). +0 and -0 compare equal.
// Ports:
//   a, b    : input  [BITSIZE-1:0] sign-magnitude operands
//   a_gt_b  : output               1 when a is strictly greater than b
// -----------------------------------------------------------------------------
module sm_compare
    import arrhythmia_pkg::*;
#(
    parameter int BITSIZE = DEFAULT_BITSIZE
) (
    input  logic [BITSIZE-1:0] a,
    input  logic [BITSIZE-1:0] b,
    output logic               a_gt_b
);

    logic               a_neg;
    logic               b_neg;
    logic [BITSIZE-2:0] a_mag;
    logic [BITSIZE-2:0] b_mag;

    assign a_neg = a[BITSIZE-1];
    assign b_neg = b[BITSIZE-1];
    assign a_mag = a[BITSIZE-2:0];
    assign b_mag = b[BITSIZE-2:0];

    always_comb begin
        // NOTE: a_gt_b is assigned on every path so no latch is inferred.
        a_gt_b = 1'b0;
        if ((a_mag == '0) && (b_mag == '0)) begin
            a_gt_b = 1'b0;                 // both zeros, whatever their signs
        end else if (a_neg != b_neg) begin
            a_gt_b = !a_neg;               // the non-negative one is larger
        end else if (!a_neg) begin
            a_gt_b = (a_mag > b_mag);
        end else begin
            a_gt_b = (a_mag < b_mag);      // both negative: smaller magnitude wins
        end
    end

endmodule : sm_compare

// File: rtl/arrhythmia_score_unit.sv
// -----------------------------------------------------------------------------
// arrhythmia_score_unit
// Scores a binary classifier run: each done_flag delivers scores {y1,y2};
// pred = (y1 > y2) in sign-magnitude. Each prediction is paired with a
// ground-truth label (one-entry buffer, or same-cycle bypass) and counted.
// Optional macro ARRHY_SCORE_CONFUSION_EN adds confusion-matrix counters.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, num_cases      : begin a run of num_cases cases
//   y, done_flag          : classifier scores {y1,y2} and their valid pulse
//   label_valid/label/label_ready : ground-truth handshake
//   pred, pred_valid      : scored prediction and its one-cycle strobe
//   total_count, true_count : cases scored / cases correct (saturating)
//   run_done, overrun     : run complete (level) / unexpected done_flag (sticky)
//   tp/tn/fp/fn_count     : confusion counters (ARRHY_SCORE_CONFUSION_EN only)
// -----------------------------------------------------------------------------
module arrhythmia_score_unit
    import arrhythmia_pkg::*;
#(
    parameter  int BITSIZE  = DEFAULT_BITSIZE,
    parameter  int MAX_DATA = DEFAULT_MAX_DATA,
    localparam int CW       = $clog2(MAX_DATA + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CW-1:0]        num_cases,
    input  logic [2*BITSIZE-1:0] y,
    input  logic                 done_flag,
    input  logic                 label_valid,
    input  logic                 label,
    output logic                 label_ready,
    output logic                 pred,
    output logic                 pred_valid,
    output logic [CW-1:0]        total_count,
    output logic [CW-1:0]        true_count,
    output logic                 run_done,
    output logic                 overrun
`ifdef ARRHY_SCORE_CONFUSION_EN
    ,
    output logic [CW-1:0]        tp_count,
    output logic [CW-1:0]        tn_count,
    output logic [CW-1:0]        fp_count,
    output logic [CW-1:0]        fn_count
`endif
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DATA);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x >= CNT_MAX) ? x : x + CW'(1);
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] num_cases_q, num_cases_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW-1:0] true_q, true_d;
    logic          pred_q, pred_d;
    logic          pred_valid_q, pred_valid_d;
    logic          pend_pred_q, pend_pred_d;   // prediction waiting for its label
    logic          buf_full_q, buf_full_d;
    logic          buf_label_q, buf_label_d;
    logic          overrun_q, overrun_d;

    logic          y_gt;
    logic          ready;
    logic          xfer;
    logic          run_clear;
    logic          score_en;
    logic          score_pred;
    logic          score_label;

    sm_compare #(.BITSIZE(BITSIZE)) u_sm_compare (
        .a      (y[2*BITSIZE-1:BITSIZE]),
        .b      (y[BITSIZE-1:0]),
        .a_gt_b (y_gt)
    );

    assign ready = !buf_full_q && ((state_q == RUN) || (state_q == WAIT_LABEL));
    assign xfer  = label_valid && ready;

    always_comb begin
        state_d      = state_q;
        num_cases_d  = num_cases_q;
        total_d      = total_q;
        true_d       = true_q;
        pred_d       = pred_q;
        pred_valid_d = 1'b0;
        pend_pred_d  = pend_pred_q;
        buf_full_d   = buf_full_q;
        buf_label_d  = buf_label_q;
        overrun_d    = overrun_q;
        run_clear    = 1'b0;
        score_en     = 1'b0;
        score_pred   = 1'b0;
        score_label  = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    run_clear   = 1'b1;
                    num_cases_d = num_cases;
                    total_d     = '0;
                    true_d      = '0;
                    overrun_d   = 1'b0;
                    buf_full_d  = 1'b0;
                    state_d     = (num_cases == '0) ? DONE : RUN;
                end else if (done_flag) begin
                    overrun_d = 1'b1;
                end
            end
            RUN: begin
                if (done_flag) begin
                    if (buf_full_q) begin
                        score_en    = 1'b1;
                        score_pred  = y_gt;
                        score_label = buf_label_q;
                        buf_full_d  = 1'b0;
                    end else if (xfer) begin
                        // Label arriving with the scores belongs to this case.
                        score_en    = 1'b1;
                        score_pred  = y_gt;
                        score_label = label;
                    end else begin
                        pend_pred_d = y_gt;
                        state_d     = WAIT_LABEL;
                    end
                end else if (xfer) begin
                    buf_full_d  = 1'b1;
                    buf_label_d = label;
                end
            end
            WAIT_LABEL: begin
                if (done_flag) begin
                    overrun_d = 1'b1;
                end
                if (xfer) begin
                    score_en    = 1'b1;
                    score_pred  = pend_pred_q;
                    score_label = label;
                    state_d     = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (score_en) begin
            pred_d       = score_pred;
            pred_valid_d = 1'b1;
            total_d      = sat_inc(total_q);
            if (score_pred == score_label) begin
                true_d = sat_inc(true_q);
            end
            if (total_d >= num_cases_q) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= IDLE;
            num_cases_q  <= '0;
            total_q      <= '0;
            true_q       <= '0;
            pred_q       <= 1'b0;
            pred_valid_q <= 1'b0;
            pend_pred_q  <= 1'b0;
            buf_full_q   <= 1'b0;
            buf_label_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_cases_q  <= num_cases_d;
            total_q      <= total_d;
            true_q       <= true_d;
            pred_q       <= pred_d;
            pred_valid_q <= pred_valid_d;
            pend_pred_q  <= pend_pred_d;
            buf_full_q   <= buf_full_d;
            buf_label_q  <= buf_label_d;
            overrun_q    <= overrun_d;
        end
    end

    assign label_ready = ready;
    assign pred        = pred_q;
    assign pred_valid  = pred_valid_q;
    assign total_count = total_q;
    assign true_count  = true_q;
    assign run_done    = (state_q == DONE);
    assign overrun     = overrun_q;

`ifdef ARRHY_SCORE_CONFUSION_EN
    logic [CW-1:0] tp_q, tp_d, tn_q, tn_d, fp_q, fp_d, fn_q, fn_d;

    always_comb begin
        tp_d = tp_q;
        tn_d = tn_q;
        fp_d = fp_q;
        fn_d = fn_q;
        if (run_clear) begin
            tp_d = '0;
            tn_d = '0;
            fp_d = '0;
            fn_d = '0;
        end else if (score_en) begin
            unique case ({score_pred, score_label})
                2'b11:   tp_d = sat_inc(tp_q);
                2'b00:   tn_d = sat_inc(tn_q);
                2'b10:   fp_d = sat_inc(fp_q);
                default: fn_d = sat_inc(fn_q);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tp_q <= '0;
            tn_q <= '0;
            fp_q <= '0;
            fn_q <= '0;
        end else begin
            tp_q <= tp_d;
            tn_q <= tn_d;
            fp_q <= fp_d;
            fn_q <= fn_d;
        end
    end

    assign tp_count = tp_q;
    assign tn_count = tn_q;
    assign fp_count = fp_q;
    assign fn_count = fn_q;
`endif

endmodule : arrhythmia_score_unit

// File: tb/tb_arrhythmia_score_unit.sv
// -----------------------------------------------------------------------------
// tb_arrhythmia_score_unit
// Directed self-checking bench for arrhythmia_score_unit (default build).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
// -----------------------------------------------------------------------------
module tb_arrhythmia_score_unit;

    localparam int BITSIZE  = 20;
    localparam int MAX_DATA = 101;
    localparam int CW       = $clog2(MAX_DATA + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CW-1:0]        num_cases;
    logic [2*BITSIZE-1:0] y;
    logic                 done_flag;
    logic                 label_valid;
    logic                 label;
    logic                 label_ready;
    logic                 pred;
    logic                 pred_valid;
    logic [CW-1:0]        total_count;
    logic [CW-1:0]        true_count;
    logic                 run_done;
    logic                 overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arrhythmia_score_unit #(.BITSIZE(BITSIZE), .MAX_DATA(MAX_DATA)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_cases   (num_cases),
        .y           (y),
        .done_flag   (done_flag),
        .label_valid (label_valid),
        .label       (label),
        .label_ready (label_ready),
        .pred        (pred),
        .pred_valid  (pred_valid),
        .total_count (total_count),
        .true_count  (true_count),
        .run_done    (run_done),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_cases = CW'(n);
        tick();
        start     = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int pv, input int p, input int tot,
                              input int tru, input int rd, input int ov);
        check({tag, ".pred_valid"}, 32'(pred_valid), pv);
        check({tag, ".pred"},       32'(pred), p);
        check({tag, ".total"},      32'(total_count), tot);
        check({tag, ".true"},       32'(true_count), tru);
        check({tag, ".run_done"},   32'(run_done), rd);
        check({tag, ".overrun"},    32'(overrun), ov);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        num_cases   = '0;
        y           = '0;
        done_flag   = 1'b0;
        label_valid = 1'b0;
        label       = 1'b0;
        tick();
        tick();
        check_outs("reset", 0, 0, 0, 0, 0, 0);
        check("reset.label_ready", 32'(label_ready), 0);
        reset = 1'b0;
        tick();

        // Case 1: buffered label, y1 positive vs y2 negative.
        do_start(1);
        check("c1.ready_in_run", 32'(label_ready), 1);
        label_valid = 1'b1;
        label       = 1'b1;
        tick();
        check("c1.ready_full", 32'(label_ready), 0);
        y         = {20'h00010, 20'h80020};
        done_flag = 1'b1;
        tick();
        done_flag   = 1'b0;
        label_valid = 1'b0;
        check_outs("c1", 1, 1, 1, 1, 1, 0);
        tick();
        check_outs("c1.hold", 0, 1, 1, 1, 1, 0);

        // Case 2: both negative, then +0 vs -0.
        do_start(2);
        check_outs("c2.start", 0, 1, 0, 0, 0, 0);
        label_valid = 1'b1;
        label       = 1'b0;
        tick();
        label_valid = 1'b0;
        y         = {20'h80005, 20'h80003};
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check_outs("c2.neg", 1, 0, 1, 1, 0, 0);
        label_valid = 1'b1;
        label       = 1'b1;
        tick();
        label_valid = 1'b0;
        y         = {20'h80000, 20'h00000};
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check_outs("c2.zero", 1, 0, 2, 1, 1, 0);

        // Case 3: late label, overrun while waiting, then same-cycle bypass.
        do_start(2);
        y         = {20'h00003, 20'h00001};
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check_outs("c3.wait", 0, 0, 0, 0, 0, 0);
        check("c3.ready_wait", 32'(label_ready), 1);
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check_outs("c3.overrun", 0, 0, 0, 0, 0, 1);
        tick();
        label_valid = 1'b1;
        label       = 1'b0;
        tick();
        label_valid = 1'b0;
        check_outs("c3.late", 1, 1, 1, 0, 0, 1);
        tick();
        check("c3.strobe_once", 32'(pred_valid), 0);
        y           = {20'h00000, 20'h80001};
        done_flag   = 1'b1;
        label_valid = 1'b1;
        label       = 1'b1;
        tick();
        done_flag   = 1'b0;
        label_valid = 1'b0;
        check_outs("c3.bypass", 1, 1, 2, 2 - 1, 1, 1);

        // Case 4: full run of MAX_DATA cases, alternating correct/incorrect.
        do_start(MAX_DATA);
        check_outs("c4.start", 0, 1, 0, 0, 0, 0);
        y = {20'h00002, 20'h00001};
        for (int i = 0; i < MAX_DATA; i++) begin
            done_flag   = 1'b1;
            label_valid = 1'b1;
            label       = (i % 2 == 0);
            tick();
        end
        done_flag   = 1'b0;
        label_valid = 1'b0;
        check_outs("c4.end", 1, 1, 101, 51, 1, 0);
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check_outs("c4.extra", 0, 1, 101, 51, 1, 1);

        // Case 5: num_cases = 0 goes straight to done.
        do_start(0);
        check_outs("c5.zero_run", 0, 1, 0, 0, 1, 0);

        // Case 6: reset while waiting for a label, then a clean run.
        do_start(3);
        y         = {20'h00001, 20'h00002};
        done_flag = 1'b1;
        tick();
        done_flag = 1'b0;
        check("c6.ready_wait", 32'(label_ready), 1);
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check_outs("c6.reset", 0, 0, 0, 0, 0, 0);
        check("c6.ready_idle", 32'(label_ready), 0);
        do_start(1);
        done_flag   = 1'b1;
        label_valid = 1'b1;
        label       = 1'b0;
        tick();
        done_flag   = 1'b0;
        label_valid = 1'b0;
        check_outs("c6.clean", 1, 0, 1, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_arrhythmia_score_unit

// File: doc/arrhythmia_score_unit.md
ARRHYTHMIA_SCORE_UNIT -- requirements
Module: arrhythmia_score_unit

Interface
REQ-001 SHALL have parameter BITSIZE, default 20, width of each classifier output score.
REQ-002 SHALL have parameter MAX_DATA, default 101, maximum test cases per run; counters are CW = $clog2(MAX_DATA+1) bits wide.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse beginning a run.
REQ-006 SHALL have port num_cases, input, CW, cases expected in the run, sampled on start.
REQ-007 SHALL have port y, input, 2*BITSIZE, classifier scores {y1,y2}, each sign-magnitude.
REQ-008 SHALL have port done_flag, input, 1, one-cycle pulse marking y valid.
REQ-009 SHALL have ports label_valid (input, 1), label (input, 1), label_ready (output, 1): ground-truth class handshake.
REQ-010 SHALL have ports pred (output, 1) and pred_valid (output, 1), the scored prediction and its one-cycle strobe.
REQ-011 SHALL have ports total_count and true_count, outputs, CW, cases scored and cases correct.
REQ-012 SHALL have ports run_done (output, 1, level) and overrun (output, 1, sticky).

Function
REQ-013 SHALL implement FSM IDLE, RUN, WAIT_LABEL, DONE; reset state IDLE.
REQ-014 IDLE: start -> clear counters/overrun, latch num_cases, go RUN; start with num_cases=0 -> go DONE directly.
REQ-015 pred SHALL be 1 iff y1 > y2 under sign-magnitude: MSB sign, low BITSIZE-1 bits magnitude; differing signs -> positive larger; both negative -> smaller magnitude larger; +0 and -0 equal -> pred 0.
REQ-016 SHALL hold a one-entry label buffer; label_ready = buffer empty and state in {RUN, WAIT_LABEL}; transfer on label_valid & label_ready.
REQ-017 RUN, done_flag with buffer full: next cycle pred_valid=1, pred driven, total_count+1, true_count+1 if pred==label, buffer emptied.
REQ-018 RUN, done_flag with buffer empty: register pred, go WAIT_LABEL; on label transfer, score next cycle per REQ-017, return RUN.
REQ-019 Label transfer and done_flag in same cycle with buffer empty: label SHALL be used for that case (bypass), scored next cycle.
REQ-020 done_flag in WAIT_LABEL, IDLE or DONE: SHALL set overrun, SHALL NOT change counters.
REQ-021 When total_count reaches latched num_cases: go DONE, run_done=1; start in DONE behaves as in IDLE.
REQ-022 Counters SHALL saturate at MAX_DATA; no wrap-around.
REQ-023 pred, total_count, true_count SHALL hold values between strobes and through DONE.

Reset
REQ-024 reset SHALL force state IDLE, pred=0, pred_valid=0, label buffer empty, counters 0, run_done=0, overrun=0, label_ready=0.
REQ-025 reset asserted mid-run SHALL discard the in-flight case and buffered label; reset dominates start.

Configuration
REQ-026 Macro ARRHY_SCORE_CONFUSION_EN defined: add outputs tp_count, tn_count, fp_count, fn_count (CW each, cleared on start/reset, incremented with pred_valid per pred/label pair, saturating); undefined: ports and logic absent, remaining behaviour identical.

Structure
REQ-027 Shared package arrhythmia_pkg SHALL hold the FSM state enum and default BITSIZE/MAX_DATA constants.
REQ-028 Sign-magnitude compare SHALL be a sub-module sm_compare (combinational, parameter BITSIZE, output a_gt_b).

Verification
REQ-029 start, num_cases=1; label 1 held; done_flag with y1=20'h00010, y2=20'h80020 -> next cycle pred=1, pred_valid=1, true_count=1, total_count=1, run_done=1.
REQ-030 y1=20'h80005, y2=20'h80003 (both negative), label 0 -> pred=0, true_count increments.
REQ-031 y1=20'h80000, y2=20'h00000 -> pred=0 (±0 equal).
REQ-032 done_flag with no label, label arrives 3 cycles later -> WAIT_LABEL, pred_valid exactly 1 cycle after label transfer; second done_flag while waiting -> overrun=1, counts unchanged.
REQ-033 num_cases=101, alternating correct/incorrect cases -> total_count=101, true_count=51, run_done=1; extra done_flag -> overrun=1, counters stay 101/51.
REQ-034 reset pulsed with case in WAIT_LABEL -> all outputs 0, state IDLE; new start scores cleanly from zero.
